mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the five-stage LoongArch-style core, directly downstream of `EX_stage` and upstream of `WB_stage`. It latches the EX bundle, takes the synchronous data-SRAM read data that returns one cycle after EX issues the request, and extracts and sign/zero-extends the load data. It then forwards the final result to WB and back to ID. A one-entry read-data hold buffer keeps load data correct while WB back-pressures this stage.

## Interface
Parameters: none. Widths come from `constants.h` macros `to_MEM_data_width`, `to_WB_data_width`, `MEM_forward_width`, `CSR_NUM_WIDTH`.
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- csr_reset  in  1  exception/ertn flush from WB; synchronous, same effect as reset on stage state
- WB_allow_in  in  1  WB can accept an instruction this cycle
- EX_to_MEM_valid  in  1  EX offers an instruction
- to_MEM_data  in  `to_MEM_data_width`  {pc, alu_result, rd1, rd2, rd4, rd_signed, dest[4:0], gr_we, ex_INT, ex_SYS, ex_BRK, ex_ADEF, ex_ADEM, ex_INE, is_ertn, op_csr, csr_num, csr_wmask[31:0], rj[4:0], rdcntvh, rdcntvl, rdcntid}, MSB first
- data_sram_rdata  in  32  SRAM read word for the request EX issued in the previous cycle
- MEM_allow_in  out  1  stage can accept from EX
- MEM_to_WB_valid  out  1  stage offers an instruction to WB
- to_WB_data  out  `to_WB_data_width`  {pc, final_result, dest, gr_we, ex_INT, ex_SYS, ex_BRK, ex_ADEF, ex_ADEM, ex_INE, is_ertn, op_csr, csr_num, csr_wmask, rj, rdcntvh, rdcntvl, rdcntid}
- mem_ex  out  1  valid instruction in MEM carries an exception or ertn; EX uses it to suppress SRAM enables
- MEM_forward  out  `MEM_forward_width`  {MEM_dest[4:0], final_result[31:0], MEM_op_csr}

## Operation
- Registers: MEM_valid, to_MEM_data_r, rdata_buf[31:0], buf_valid, first_cycle.
- Handshake: MEM_ready_go = 1. MEM_allow_in = ~MEM_valid | WB_allow_in. MEM_to_WB_valid = MEM_valid.
- On accept (MEM_allow_in): MEM_valid <= EX_to_MEM_valid.
- On accept with EX_to_MEM_valid = 1:
  - to_MEM_data_r <= to_MEM_data.
  - first_cycle <= 1, buf_valid <= 0.
- Hold buffer: when first_cycle=1 and the stage does not hand off (MEM_valid & ~WB_allow_in):
  - rdata_buf <= data_sram_rdata, buf_valid <= 1.
  - first_cycle clears every cycle the stage does not accept a new instruction.
- Read-data selection: rdata = buf_valid ? rdata_buf : data_sram_rdata.
- Load extraction, a = alu_result[1:0]:
  - rd1 selects byte a.
  - rd2 selects half a[1].
  - rd4 selects the whole word.
  - rd_signed=1 sign-extends rd1/rd2; rd_signed=0 zero-extends them.
  - Misaligned loads carry ex_ADEM from EX; their data is don't-care.
- final_result = (rd1|rd2|rd4) ? load_data : alu_result.
- mem_ex = MEM_valid & (ex_INT|ex_SYS|ex_BRK|ex_ADEF|ex_ADEM|ex_INE|is_ertn).
- MEM_dest = dest & {5{MEM_valid & gr_we}}. MEM_op_csr = op_csr & MEM_valid.

## Timing
- Reset or csr_reset takes priority over accept. It sets MEM_valid, buf_valid and first_cycle to 0. to_MEM_data_r and rdata_buf are not reset.
- Outputs in reset: MEM_allow_in=1, MEM_to_WB_valid=0, mem_ex=0, MEM_forward dest/op_csr fields 0.
- Latency: one cycle EX→MEM. Results are combinational within MEM; there is no added load latency.
- Stall on the first MEM cycle: data_sram_rdata is captured that same cycle. Any later SRAM activity (EX re-issuing while stalled) is ignored until handoff.
- Simultaneous handoff and accept: the new instruction loads, first_cycle=1 and buf_valid=0. There is no bubble.
- Handoff with no new instruction: MEM_valid becomes 0. The buffer is not used again until the next accept.
- Flush with an instruction arriving from EX the same cycle: the flush wins and the arriving instruction is dropped.

## Structure
- Field widths and bundle-width macros (`to_WB_data_width`, `MEM_forward_width`) go in `constants.h` next to the existing ones.
- One natural sub-module: `load_align`, which is combinational. Its inputs are rdata, a, rd1, rd2, rd4 and rd_signed; its output is load_data.
- The hold buffer and handshake stay in `mem_stage`.

## Test plan
- ld.b, signed, alu_result=0x1000_0003, rdata=0x80FF_7F01, WB_allow_in=1 → final_result=0xFFFF_FF80 in the same cycle, MEM_to_WB_valid=1.
- ld.hu, alu_result=0x...2, rdata=0x8001_1234 → 0x0000_8001. ld.h on the same data → 0xFFFF_8001.
- ld.w with rdata=0xDEAD_BEEF and WB_allow_in=0 for 3 cycles while data_sram_rdata changes to 0x0 → final_result stays 0xDEAD_BEEF, and WB receives 0xDEAD_BEEF on release.
- Back-to-back ld.w/add with WB_allow_in=1 → the two accepts are consecutive with no bubble. The add's final_result=alu_result, and MEM_forward dest matches per cycle.
- ex_ADEM load valid in MEM → mem_ex=1. Then csr_reset=1 with EX_to_MEM_valid=1 → next cycle MEM_valid=0, MEM_allow_in=1.
- reset asserted mid-stall with buf_valid=1 → the next instruction reads data_sram_rdata directly, not the stale buffer.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths and bundle layouts for the memory-access stage.
// Bundles are packed MSB-first in the same field order EX and WB use.
package mem_stage_pkg;

   localparam int CSR_NUM_WIDTH      = 14;
   localparam int TO_MEM_DATA_WIDTH  = 136;
   localparam int TO_WB_DATA_WIDTH   = 132;
   localparam int MEM_FORWARD_WIDTH  = 38;

   typedef struct packed {
      logic [31:0]              pc;
      logic [31:0]              alu_result;
      logic                     rd1;
      logic                     rd2;
      logic                     rd4;
      logic                     rd_signed;
      logic [4:0]               dest;
      logic                     gr_we;
      logic                     ex_int;
      logic                     ex_sys;
      logic                     ex_brk;
      logic                     ex_adef;
      logic                     ex_adem;
      logic                     ex_ine;
      logic                     is_ertn;
      logic                     op_csr;
      logic [CSR_NUM_WIDTH-1:0] csr_num;
      logic [31:0]              csr_wmask;
      logic [4:0]               rj;
      logic                     rdcntvh;
      logic                     rdcntvl;
      logic                     rdcntid;
   } mem_bundle_t;

   typedef struct packed {
      logic [31:0]              pc;
      logic [31:0]              final_result;
      logic [4:0]               dest;
      logic                     gr_we;
      logic                     ex_int;
      logic                     ex_sys;
      logic                     ex_brk;
      logic                     ex_adef;
      logic                     ex_adem;
      logic                     ex_ine;
      logic                     is_ertn;
      logic                     op_csr;
      logic [CSR_NUM_WIDTH-1:0] csr_num;
      logic [31:0]              csr_wmask;
      logic [4:0]               rj;
      logic                     rdcntvh;
      logic                     rdcntvl;
      logic                     rdcntid;
   } wb_bundle_t;

   typedef struct packed {
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic        op_csr;
   } mem_forward_t;

   function automatic logic has_exception(input mem_bundle_t b);
      return b.ex_int | b.ex_sys | b.ex_brk | b.ex_adef | b.ex_adem | b.ex_ine | b.is_ertn;
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: byte/half/word select with sign or zero extension.
module load_align (
   input  logic [31:0] rdata_i,
   input  logic [1:0]  a_i,
   input  logic        rd1_i,
   input  logic        rd2_i,
   input  logic        rd4_i,
   input  logic        rd_signed_i,
   output logic [31:0] load_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[7:0];
      unique case (a_i)
         2'd0: byte_sel = rdata_i[7:0];
         2'd1: byte_sel = rdata_i[15:8];
         2'd2: byte_sel = rdata_i[23:16];
         2'd3: byte_sel = rdata_i[31:24];
      endcase
      half_sel = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      load_data_o = rdata_i;
      if (rd4_i) begin
         load_data_o = rdata_i;
      end else if (rd1_i) begin
         load_data_o = {{24{rd_signed_i & byte_sel[7]}}, byte_sel};
      end else if (rd2_i) begin
         load_data_o = {{16{rd_signed_i & half_sel[15]}}, half_sel};
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EX bundle, aligns SRAM load data,
// and holds the first-cycle read word while WB back-pressures.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         csr_reset,
   input  logic                         WB_allow_in,
   input  logic                         EX_to_MEM_valid,
   input  logic [TO_MEM_DATA_WIDTH-1:0] to_MEM_data,
   input  logic [31:0]                  data_sram_rdata,
   output logic                         MEM_allow_in,
   output logic                         MEM_to_WB_valid,
   output logic [TO_WB_DATA_WIDTH-1:0]  to_WB_data,
   output logic                         mem_ex,
   output logic [MEM_FORWARD_WIDTH-1:0] MEM_forward
);

   logic        valid_q, valid_d;
   logic        first_q, first_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] buf_q, buf_d;
   mem_bundle_t data_q, data_d;

   logic         [31:0] rdata;
   logic         [31:0] load_data;
   logic         [31:0] final_result;
   wb_bundle_t          wb;
   mem_forward_t        fwd;

   assign MEM_allow_in    = ~valid_q | WB_allow_in;
   assign MEM_to_WB_valid = valid_q;

   // The SRAM word is only valid in the first MEM cycle; a stall then latches it.
   always_comb begin
      valid_d     = valid_q;
      first_d     = 1'b0;
      buf_valid_d = buf_valid_q;
      buf_d       = buf_q;
      data_d      = data_q;
      if (MEM_allow_in) begin
         valid_d = EX_to_MEM_valid;
         if (EX_to_MEM_valid) begin
            data_d      = mem_bundle_t'(to_MEM_data);
            first_d     = 1'b1;
            buf_valid_d = 1'b0;
         end
      end else if (first_q) begin
         buf_d       = data_sram_rdata;
         buf_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset | csr_reset) begin
         valid_q     <= 1'b0;
         first_q     <= 1'b0;
         buf_valid_q <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         first_q     <= first_d;
         buf_valid_q <= buf_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
      buf_q  <= buf_d;
   end

   assign rdata = buf_valid_q ? buf_q : data_sram_rdata;

   load_align u_load_align (
      .rdata_i     (rdata),
      .a_i         (data_q.alu_result[1:0]),
      .rd1_i       (data_q.rd1),
      .rd2_i       (data_q.rd2),
      .rd4_i       (data_q.rd4),
      .rd_signed_i (data_q.rd_signed),
      .load_data_o (load_data)
   );

   assign final_result = (data_q.rd1 | data_q.rd2 | data_q.rd4) ? load_data : data_q.alu_result;

   always_comb begin
      wb.pc           = data_q.pc;
      wb.final_result = final_result;
      wb.dest         = data_q.dest;
      wb.gr_we        = data_q.gr_we;
      wb.ex_int       = data_q.ex_int;
      wb.ex_sys       = data_q.ex_sys;
      wb.ex_brk       = data_q.ex_brk;
      wb.ex_adef      = data_q.ex_adef;
      wb.ex_adem      = data_q.ex_adem;
      wb.ex_ine       = data_q.ex_ine;
      wb.is_ertn      = data_q.is_ertn;
      wb.op_csr       = data_q.op_csr;
      wb.csr_num      = data_q.csr_num;
      wb.csr_wmask    = data_q.csr_wmask;
      wb.rj           = data_q.rj;
      wb.rdcntvh      = data_q.rdcntvh;
      wb.rdcntvl      = data_q.rdcntvl;
      wb.rdcntid      = data_q.rdcntid;

      fwd.dest         = data_q.dest & {5{valid_q & data_q.gr_we}};
      fwd.final_result = final_result;
      fwd.op_csr       = data_q.op_csr & valid_q;
   end

   assign to_WB_data  = wb;
   assign MEM_forward = fwd;
   assign mem_ex      = valid_q & has_exception(data_q);

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against an instruction-level model.
module tb_mem_stage;
   import mem_stage_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu;
      logic        rd1, rd2, rd4, sg;
      logic [4:0]  dest;
      logic        gr_we;
      logic [5:0]  exc;
      logic        ertn;
      logic        op_csr;
      logic [13:0] csr_num;
      logic [31:0] wmask;
      logic [4:0]  rj;
      logic [2:0]  cnt;
   } instr_t;

   logic                         clk = 1'b0;
   logic                         reset = 1'b1;
   logic                         csr_reset = 1'b0;
   logic                         WB_allow_in = 1'b1;
   logic                         EX_to_MEM_valid = 1'b0;
   instr_t                       ins = '0;
   logic [31:0]                  data_sram_rdata = '0;
   logic                         MEM_allow_in;
   logic                         MEM_to_WB_valid;
   logic [TO_WB_DATA_WIDTH-1:0]  to_WB_data;
   logic                         mem_ex;
   logic [MEM_FORWARD_WIDTH-1:0] MEM_forward;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Model: the instruction in MEM and the SRAM word seen on its first cycle.
   logic        m_valid = 1'b0;
   logic        m_fresh = 1'b0;
   instr_t      m_ins = '0;
   logic [31:0] m_word = '0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk             (clk),
      .reset           (reset),
      .csr_reset       (csr_reset),
      .WB_allow_in     (WB_allow_in),
      .EX_to_MEM_valid (EX_to_MEM_valid),
      .to_MEM_data     (ins),
      .data_sram_rdata (data_sram_rdata),
      .MEM_allow_in    (MEM_allow_in),
      .MEM_to_WB_valid (MEM_to_WB_valid),
      .to_WB_data      (to_WB_data),
      .mem_ex          (mem_ex),
      .MEM_forward     (MEM_forward)
   );

   function automatic logic [31:0] ref_result(input instr_t i, input logic [31:0] w);
      logic [31:0] v;
      int unsigned sh;
      if (i.rd4) return w;
      if (i.rd1) begin
         sh = 8 * int'(i.alu[1:0]);
         v  = (w >> sh) & 32'hFF;
         if (i.sg && v >= 32'd128) v = v - 32'd256;
         return v;
      end
      if (i.rd2) begin
         sh = 16 * int'(i.alu[1]);
         v  = (w >> sh) & 32'hFFFF;
         if (i.sg && v >= 32'd32768) v = v - 32'd65536;
         return v;
      end
      return i.alu;
   endfunction

   task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // kind: 0 ld.b 1 ld.bu 2 ld.h 3 ld.hu 4 ld.w 5 alu
   task automatic mk(input int unsigned kind, input logic [31:0] alu);
      ins         = '0;
      ins.pc      = $urandom & 32'hFFFF_FFFC;
      ins.alu     = alu;
      ins.rd1     = (kind <= 1);
      ins.rd2     = (kind == 2 || kind == 3);
      ins.rd4     = (kind == 4);
      ins.sg      = (kind == 0 || kind == 2);
      ins.dest    = 5'($urandom_range(1, 31));
      ins.gr_we   = 1'b1;
      ins.csr_num = 14'($urandom);
      ins.wmask   = $urandom;
      ins.rj      = 5'($urandom);
      ins.cnt     = 3'($urandom);
      ins.op_csr  = (kind == 5) ? 1'($urandom) : 1'b0;
   endtask

   task automatic tick();
      logic [31:0] f;
      #1;
      if (m_fresh) begin
         m_word  = data_sram_rdata;
         m_fresh = 1'b0;
      end
      f = ref_result(m_ins, m_word);
      chk("allow_in", MEM_allow_in, !m_valid || WB_allow_in);
      chk("to_wb_valid", MEM_to_WB_valid, m_valid);
      chk("mem_ex", mem_ex, m_valid && (|m_ins.exc || m_ins.ertn));
      if (m_valid) begin
         chk("to_wb_data", to_WB_data, {m_ins.pc, f, m_ins.dest, m_ins.gr_we, m_ins.exc, m_ins.ertn,
                                        m_ins.op_csr, m_ins.csr_num, m_ins.wmask, m_ins.rj, m_ins.cnt});
         chk("forward", MEM_forward, {(m_ins.gr_we ? m_ins.dest : 5'd0), f, m_ins.op_csr});
      end else begin
         chk("fwd_dest_idle", MEM_forward[37:33], 5'd0);
         chk("fwd_csr_idle", MEM_forward[0], 1'b0);
      end
      @(posedge clk);
      if (reset || csr_reset) begin
         m_valid = 1'b0;
      end else if (!m_valid || WB_allow_in) begin
         m_valid = EX_to_MEM_valid;
         if (EX_to_MEM_valid) begin
            m_ins   = ins;
            m_fresh = 1'b1;
         end
      end
      #1;
   endtask

   task automatic expect_final(input string tag, input logic [31:0] v);
      #1;
      chk(tag, to_WB_data[99:68], v);
      chk({tag, "_valid"}, MEM_to_WB_valid, 1'b1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      tick();                       // reset still asserted: idle outputs
      reset = 1'b0;

      // ld.b signed from byte 3
      mk(0, 32'h1000_0003); EX_to_MEM_valid = 1'b1; WB_allow_in = 1'b1; tick();
      EX_to_MEM_valid = 1'b0; data_sram_rdata = 32'h80FF_7F01;
      expect_final("ld_b", 32'hFFFF_FF80); tick();

      // ld.hu then ld.h back to back on the same word
      mk(3, 32'h2000_0002); EX_to_MEM_valid = 1'b1; tick();
      mk(2, 32'h2000_0002); data_sram_rdata = 32'h8001_1234;
      expect_final("ld_hu", 32'h0000_8001); tick();
      EX_to_MEM_valid = 1'b0;
      expect_final("ld_h", 32'hFFFF_8001); tick();

      // ld.w stalled three cycles while SRAM data changes
      mk(4, 32'h3000_0010); EX_to_MEM_valid = 1'b1; tick();
      EX_to_MEM_valid = 1'b0; WB_allow_in = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
      expect_final("ldw_stall0", 32'hDEAD_BEEF); tick();
      data_sram_rdata = 32'h0;
      expect_final("ldw_stall1", 32'hDEAD_BEEF); tick();
      expect_final("ldw_stall2", 32'hDEAD_BEEF); tick();
      WB_allow_in = 1'b1;
      expect_final("ldw_release", 32'hDEAD_BEEF); tick();

      // ld.w followed immediately by add
      mk(4, 32'h0000_0040); EX_to_MEM_valid = 1'b1; tick();
      mk(5, 32'h1234_5678); data_sram_rdata = 32'hCAFE_F00D;
      expect_final("b2b_ldw", 32'hCAFE_F00D); tick();
      EX_to_MEM_valid = 1'b0;
      expect_final("b2b_add", 32'h1234_5678); tick();

      // ADEM load, then flush colliding with an arriving instruction
      mk(4, 32'h0000_0082); ins.exc = 6'b000010; EX_to_MEM_valid = 1'b1; tick();
      mk(5, 32'h5555_AAAA); WB_allow_in = 1'b0;
      #1; chk("adem_mem_ex", mem_ex, 1'b1); tick();
      csr_reset = 1'b1; tick();
      csr_reset = 1'b0; EX_to_MEM_valid = 1'b0; WB_allow_in = 1'b1;
      #1; chk("flush_valid", MEM_to_WB_valid, 1'b0); chk("flush_allow", MEM_allow_in, 1'b1); tick();

      // reset while stalled with a buffered word
      mk(4, 32'h0000_0100); EX_to_MEM_valid = 1'b1; tick();
      EX_to_MEM_valid = 1'b0; WB_allow_in = 1'b0; data_sram_rdata = 32'h1111_1111; tick();
      data_sram_rdata = 32'h2222_2222; tick();
      reset = 1'b1; tick();
      reset = 1'b0; mk(4, 32'h0000_0200); EX_to_MEM_valid = 1'b1; WB_allow_in = 1'b1; tick();
      EX_to_MEM_valid = 1'b0; data_sram_rdata = 32'h3333_4444;
      expect_final("post_reset_direct", 32'h3333_4444); tick();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         int unsigned kind;
         logic [31:0] a;
         kind = $urandom_range(0, 5);
         a    = $urandom;
         if (kind == 2 || kind == 3) a[0] = 1'b0;
         if (kind == 4) a[1:0] = 2'b00;
         mk(kind, a);
         if ($urandom_range(0, 7) == 0) ins.exc = 6'($urandom);
         ins.ertn        = ($urandom_range(0, 15) == 0);
         ins.gr_we       = ($urandom_range(0, 3) != 0);
         EX_to_MEM_valid = 1'($urandom);
         WB_allow_in     = ($urandom_range(0, 3) != 0);
         data_sram_rdata = $urandom;
         reset           = ($urandom_range(0, 63) == 0);
         csr_reset       = ($urandom_range(0, 31) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
